// File: rtl/mem_bridge_responder.sv
// MEM-stage bridge responder: latches one CPU load/store, decodes it to DM/Timer0/Timer1,
// runs a req/ack device handshake with timeout, and returns aligned read data.
module mem_bridge_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
    parameter logic [31:0] T0_BASE  = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE  = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bridge_address,
    input  logic [31:0] bridge_write_data,
    input  logic [2:0]  bridge_write_size,
    input  logic [2:0]  bridge_read_size,
    output logic [31:0] bridge_read_data,
    output logic        bridge_accepted,
    output logic        bus_error,
    output logic [5:0]  interrupt_request,
    output logic [2:0]  dev_sel,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic [3:0]  dev_be,
    output logic        dev_we,
    output logic        dev_req,
    input  logic [2:0]  dev_ack,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] t0_rdata,
    input  logic [31:0] t1_rdata,
    input  logic        t0_irq,
    input  logic        t1_irq,
    input  logic        ext_irq
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                          state, state_nx;
    logic [31:0]                     a_q;
    logic [NUM_LANES-1:0][7:0]       wd_q;
    logic [3:0]                      be_q;
    logic [2:0]                      size_q;
    logic [2:0]                      sel_q;
    logic                            we_q;
    logic                            err_q;
    logic [CW-1:0]                   cnt;
    logic [31:0]                     rd_q;
    logic [5:0]                      irq_q;

    // Request decode, only meaningful while IDLE
    logic                            req_any, is_wr, size_ok, align_ok, timer_bad, dec_err;
    logic [2:0]                      req_size, dec_sel;
    logic [31:0]                     off0, off1;
    logic [NUM_LANES-1:0][7:0]       lane_wd;
    logic [3:0]                      req_be;

    assign req_any  = (|bridge_write_size) | (|bridge_read_size);
    assign is_wr    = |bridge_write_size;
    assign req_size = is_wr ? bridge_write_size : bridge_read_size;
    assign size_ok  = (req_size == 3'b001) || (req_size == 3'b010) || (req_size == 3'b100);
    assign align_ok = !((req_size == 3'b010) && bridge_address[0]) &&
                      !((req_size == 3'b100) && (bridge_address[1:0] != 2'b00));
    assign off0     = bridge_address - T0_BASE;
    assign off1     = bridge_address - T1_BASE;
    assign dec_sel[0] = (bridge_address <= DM_LIMIT);
    assign dec_sel[1] = (bridge_address >= T0_BASE) && (off0 < 32'd12);
    assign dec_sel[2] = (bridge_address >= T1_BASE) && (off1 < 32'd12);
    // Timers are word-only, and the count register at offset 8 is read-only
    assign timer_bad = (dec_sel[1] || dec_sel[2]) &&
                       ((req_size != 3'b100) ||
                        (is_wr && ((dec_sel[1] && off0 == 32'd8) || (dec_sel[2] && off1 == 32'd8))));
    assign dec_err  = (is_wr && (|bridge_read_size)) || !size_ok || !align_ok ||
                      (dec_sel == 3'b000) || timer_bad;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_comb begin
            case (req_size)
                3'b001:  lane_wd[i] = bridge_write_data[7:0];
                3'b010:  lane_wd[i] = bridge_write_data[8*(i%2) +: 8];
                default: lane_wd[i] = bridge_write_data[8*i +: 8];
            endcase
        end
    end

    always_comb begin
        case (req_size)
            3'b001:  req_be = 4'b0001 << bridge_address[1:0];
            3'b010:  req_be = bridge_address[1] ? 4'b1100 : 4'b0011;
            default: req_be = 4'b1111;
        endcase
    end

    // Response datapath
    logic        ack_hit, tmo;
    logic [31:0] dev_word, shifted, masked;

    assign ack_hit = |(dev_ack & sel_q);
    assign tmo     = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        dev_word = sel_q[2] ? t1_rdata : (sel_q[1] ? t0_rdata : dm_rdata);
        shifted  = dev_word >> {a_q[1:0], 3'b000};
        case (size_q)
            3'b001:  masked = {24'd0, shifted[7:0]};
            3'b010:  masked = {16'd0, shifted[15:0]};
            default: masked = shifted;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = dec_err ? RESP : WAIT;
            WAIT:    if (ack_hit || tmo) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            a_q    <= '0;
            wd_q   <= '0;
            be_q   <= '0;
            size_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
            rd_q   <= '0;
            irq_q  <= '0;
        end else begin
            state <= state_nx;
            irq_q <= {3'b000, ext_irq, t1_irq, t0_irq};
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_any) begin
                        a_q    <= bridge_address;
                        wd_q   <= lane_wd;
                        be_q   <= req_be;
                        size_q <= req_size;
                        we_q   <= is_wr;
                        sel_q  <= dec_err ? 3'b000 : dec_sel;
                        err_q  <= dec_err;
                        if (dec_err) rd_q <= '0;
                    end
                end
                WAIT: begin
                    if (ack_hit) begin
                        rd_q  <= masked;
                        err_q <= 1'b0;
                        cnt   <= '0;
                    end else if (tmo) begin
                        rd_q  <= '0;
                        err_q <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Device bus is only driven while a request is outstanding
    assign dev_req           = (state == WAIT);
    assign dev_sel           = dev_req ? sel_q : 3'b000;
    assign dev_addr          = dev_req ? {a_q[31:2], 2'b00} : 32'd0;
    assign dev_wdata         = dev_req ? wd_q : 32'd0;
    assign dev_be            = dev_req ? be_q : 4'b0000;
    assign dev_we            = dev_req & we_q;
    assign bridge_accepted   = (state == RESP);
    assign bus_error         = bridge_accepted & err_q;
    assign bridge_read_data  = rd_q;
    assign interrupt_request = irq_q;

endmodule

// File: tb/tb_mem_bridge_responder.sv
// Directed bench for mem_bridge_responder: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every accepted pulse.
module tb_mem_bridge_responder;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] bridge_address = '0;
    logic [31:0] bridge_write_data = '0;
    logic [2:0]  bridge_write_size = '0;
    logic [2:0]  bridge_read_size = '0;
    logic [31:0] bridge_read_data;
    logic        bridge_accepted;
    logic        bus_error;
    logic [5:0]  interrupt_request;
    logic [2:0]  dev_sel;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_be;
    logic        dev_we;
    logic        dev_req;
    logic [2:0]  dev_ack = '0;
    logic [31:0] dm_rdata = '0;
    logic [31:0] t0_rdata = '0;
    logic [31:0] t1_rdata = '0;
    logic        t0_irq = 1'b0;
    logic        t1_irq = 1'b0;
    logic        ext_irq = 1'b0;

    int checks = 0;
    int failures = 0;
    bit ext_watch = 1'b0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } resp_t;
    resp_t exp_q[$];

    mem_bridge_responder #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .bridge_address(bridge_address), .bridge_write_data(bridge_write_data),
        .bridge_write_size(bridge_write_size), .bridge_read_size(bridge_read_size),
        .bridge_read_data(bridge_read_data), .bridge_accepted(bridge_accepted),
        .bus_error(bus_error), .interrupt_request(interrupt_request),
        .dev_sel(dev_sel), .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be),
        .dev_we(dev_we), .dev_req(dev_req), .dev_ack(dev_ack),
        .dm_rdata(dm_rdata), .t0_rdata(t0_rdata), .t1_rdata(t1_rdata),
        .t0_irq(t0_irq), .t1_irq(t1_irq), .ext_irq(ext_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && bridge_accepted) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_accept", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_read_data", bridge_read_data, e.rd);
                chk("resp_bus_error", {31'd0, bus_error}, {31'd0, e.err});
            end
        end
        if (ext_watch) chk("ext_irq_bit", {31'd0, interrupt_request[2]}, 32'd1);
    end

    // One bridge transaction. ack_after<0 means the selected device never acks.
    task automatic access(input logic [31:0] addr, input logic [2:0] ws, input logic [2:0] rs,
                          input logic [31:0] wd, input logic [31:0] drdata, input bit imm_err,
                          input logic [2:0] exp_sel, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int ack_after, input logic [2:0] noise,
                          input logic [31:0] exp_rd, input bit exp_err);
        resp_t e;
        int req_cycles;
        bit got;
        e.rd = exp_rd;
        e.err = exp_err;
        exp_q.push_back(e);
        dm_rdata = exp_sel[0] ? drdata : 32'hBAD0_BAD0;
        t0_rdata = exp_sel[1] ? drdata : 32'hBAD1_BAD1;
        t1_rdata = exp_sel[2] ? drdata : 32'hBAD2_BAD2;
        @(negedge clk);
        bridge_address = addr;
        bridge_write_size = ws;
        bridge_read_size = rs;
        bridge_write_data = wd;
        @(posedge clk);
        #1;
        // a new request mid-transaction must be ignored
        bridge_address = 32'h0000_0020;
        bridge_read_size = 3'b100;
        bridge_write_size = 3'b000;
        @(negedge clk);
        if (imm_err) begin
            chk("imm_err_no_req", {31'd0, dev_req}, 32'd0);
            chk("imm_err_accepted", {31'd0, bridge_accepted}, 32'd1);
        end else begin
            chk("dev_sel", {29'd0, dev_sel}, {29'd0, exp_sel});
            chk("dev_be", {28'd0, dev_be}, {28'd0, exp_be});
            chk("dev_wdata", dev_wdata, exp_wd);
            chk("dev_we", {31'd0, dev_we}, {31'd0, (ws != 3'b000)});
            chk("dev_addr", dev_addr, {addr[31:2], 2'b00});
            req_cycles = 0;
            got = 1'b0;
            dev_ack = noise;
            for (int n = 0; n < 40; n++) begin
                if (dev_req) req_cycles++;
                if (n == ack_after) dev_ack = exp_sel | noise;
                @(negedge clk);
                if (bridge_accepted) begin
                    got = 1'b1;
                    break;
                end
            end
            dev_ack = 3'b000;
            chk("accept_seen", {31'd0, got}, 32'd1);
            chk("req_cycles", req_cycles, (ack_after < 0) ? TIMEOUT : ack_after + 1);
            chk("resp_no_req", {31'd0, dev_req}, 32'd0);
        end
        bridge_read_size = 3'b000;
        bridge_write_size = 3'b000;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {bridge_read_data}, 32'd0);
        chk("rst_ctrl", {22'd0, bridge_accepted, bus_error, dev_req, dev_we, dev_sel, dev_be},
            32'd0);
        chk("rst_bus", dev_addr | dev_wdata, 32'd0);
        chk("rst_irq", {26'd0, interrupt_request}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // word load from DM, ack in cycle 1
        access(32'h0000_0010, 3'b000, 3'b100, 32'h0, 32'hDEAD_BEEF, 0, 3'b001, 4'b1111,
               32'h0, 0, 3'b000, 32'hDEAD_BEEF, 0);
        // byte store 0xAB to 0x13
        access(32'h0000_0013, 3'b001, 3'b000, 32'h0000_00AB, 32'h0, 0, 3'b001, 4'b1000,
               32'hABAB_ABAB, 0, 3'b000, 32'h0, 0);
        // half load from 0x2
        access(32'h0000_0002, 3'b000, 3'b010, 32'h0, 32'h1234_5678, 0, 3'b001, 4'b1100,
               32'h0, 0, 3'b000, 32'h0000_1234, 0);
        // misaligned half -> immediate error
        access(32'h0000_0003, 3'b000, 3'b010, 32'h0, 32'h0, 1, 3'b000, 4'b0, 32'h0, 0,
               3'b000, 32'h0, 1);
        // Timer1 never acks, other acks toggled as noise -> timeout error
        access(32'h0000_7F10, 3'b000, 3'b100, 32'h0, 32'h5555_5555, 0, 3'b100, 4'b1111,
               32'h0, -1, 3'b011, 32'h0, 1);
        // store to Timer0 count register -> error
        access(32'h0000_7F08, 3'b100, 3'b000, 32'h1, 32'h0, 1, 3'b000, 4'b0, 32'h0, 0,
               3'b000, 32'h0, 1);
        // byte access to a timer -> error
        access(32'h0000_7F00, 3'b000, 3'b001, 32'h0, 32'h0, 1, 3'b000, 4'b0, 32'h0, 0,
               3'b000, 32'h0, 1);
        // both sizes, bad size code, out-of-window
        access(32'h0000_0010, 3'b100, 3'b100, 32'h0, 32'h0, 1, 3'b000, 4'b0, 32'h0, 0,
               3'b000, 32'h0, 1);
        access(32'h0000_0010, 3'b000, 3'b011, 32'h0, 32'h0, 1, 3'b000, 4'b0, 32'h0, 0,
               3'b000, 32'h0, 1);
        access(32'h0000_3000, 3'b000, 3'b001, 32'h0, 32'h0, 1, 3'b000, 4'b0, 32'h0, 0,
               3'b000, 32'h0, 1);
        // Timer0 word load, ack after 2 cycles
        access(32'h0000_7F04, 3'b000, 3'b100, 32'h0, 32'h0000_00A5, 0, 3'b010, 4'b1111,
               32'h0, 2, 3'b000, 32'h0000_00A5, 0);
        // half store replicates across lanes
        access(32'h0000_0000, 3'b010, 3'b000, 32'hFFFF_BEEF, 32'h0, 0, 3'b001, 4'b0011,
               32'hBEEF_BEEF, 0, 3'b000, 32'h0, 0);
        // byte load lane 1, with ext_irq held throughout
        ext_irq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ext_watch = 1'b1;
        access(32'h0000_0001, 3'b000, 3'b001, 32'h0, 32'h1122_3344, 0, 3'b001, 4'b0010,
               32'h0, 0, 3'b000, 32'h0000_0033, 0);
        ext_watch = 1'b0;
        ext_irq = 1'b0;
        // ack on the timeout cycle wins
        access(32'h0000_0100, 3'b000, 3'b100, 32'h0, 32'hCAFE_F00D, 0, 3'b001, 4'b1111,
               32'h0, TIMEOUT - 1, 3'b000, 32'hCAFE_F00D, 0);

        // read data holds after the response
        @(negedge clk);
        @(negedge clk);
        chk("rd_hold", bridge_read_data, 32'hCAFE_F00D);

        // reset asserted during WAIT
        @(negedge clk);
        bridge_address = 32'h0000_0010;
        bridge_read_size = 3'b100;
        @(posedge clk);
        #1;
        bridge_read_size = 3'b000;
        @(negedge clk);
        chk("wait_req_before_rst", {31'd0, dev_req}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, dev_req}, 32'd0);
        chk("rst_mid_sel", {29'd0, dev_sel}, 32'd0);
        chk("rst_mid_acc", {31'd0, bridge_accepted}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        access(32'h0000_0020, 3'b000, 3'b100, 32'h0, 32'h0BAD_F00D, 0, 3'b001, 4'b1111,
               32'h0, 0, 3'b000, 32'h0BAD_F00D, 0);

        // t1_irq single-cycle pulse
        @(negedge clk);
        t1_irq = 1'b1;
        @(negedge clk);
        t1_irq = 1'b0;
        chk("irq_t1_pulse", {26'd0, interrupt_request}, 32'h2);
        @(negedge clk);
        chk("irq_t1_clear", {26'd0, interrupt_request}, 32'h0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_bridge_responder.md
Name: mem_bridge_responder

Overview:
Responder end of the pipeline's MEM-stage bridge interface. Latches one CPU load or store, decodes the address to data memory, Timer0 or Timer1, and drives a req/ack device bus. It returns aligned read data with a one-cycle accepted pulse. It also registers device interrupt lines onto interrupt_request[7:2].

Parameters:
TIMEOUT, 16, cycles waited for dev_ack before the access completes as a bus error (≥2)
DM_LIMIT, 32'h0000_2FFF, last byte address of the data-memory window starting at 0
T0_BASE, 32'h0000_7F00, Timer0 base; window is 12 bytes
T1_BASE, 32'h0000_7F10, Timer1 base; window is 12 bytes

Ports:
clk  in  1  system clock; one clock domain
reset  in  1  reset is asynchronous and active-low
bridge_address  in  32  CPU byte address
bridge_write_data  in  32  store data, right-aligned
bridge_write_size  in  3  000 none, 001 byte, 010 half, 100 word
bridge_read_size  in  3  same encoding as bridge_write_size
bridge_read_data  out  32  load data, right-aligned, zero-extended
bridge_accepted  out  1  one-cycle completion pulse
bus_error  out  1  valid with bridge_accepted: access faulted
interrupt_request  out  6  bits [7:2] to CPU
dev_sel  out  3  one-hot {T1,T0,DM}
dev_addr  out  32  word address {addr[31:2],2'b00}
dev_wdata  out  32  store data shifted to byte lane
dev_be  out  4  byte enables
dev_we  out  1  write strobe qualifier
dev_req  out  1  request, held until ack
dev_ack  in  3  per-device acknowledge {T1,T0,DM}
dm_rdata, t0_rdata, t1_rdata  in  32 each  device read words
t0_irq, t1_irq, ext_irq  in  1 each  device interrupt lines

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0: dev_sel, dev_req, dev_we, dev_be, dev_addr, dev_wdata, bridge_read_data, bridge_accepted, bus_error, interrupt_request. The timeout counter is 0.
- States are IDLE, WAIT, RESP.
- IDLE: when either size field is nonzero, latch address, data, sizes and op, then decode.
  - Valid decode goes to WAIT.
  - Invalid decode goes to RESP with error set.
  - Invalid decode means: both sizes nonzero; a size code other than 001, 010 or 100; halfword with addr[0]=1; word with addr[1:0]≠0; address outside all three windows; a store to Timer offset 8 (count register, read-only).
- WAIT:
  - dev_req=1 and dev_sel is the decoded device.
  - dev_be: byte uses 1<<addr[1:0]; half uses 0011 or 1100 by addr[1]; word uses 1111.
  - Timer accesses must be word-sized; otherwise the access is an error, caught in IDLE.
  - dev_wdata replicates the byte or half across lanes.
  - When dev_ack of the selected device is 1, capture its rdata, shift right by 8·addr[1:0], mask to the access size, and go to RESP.
  - Ack bits of non-selected devices are ignored.
  - Each cycle in WAIT increments the counter. When the counter reaches TIMEOUT-1 without ack, go to RESP with error; the counter then clears.
- RESP: bridge_accepted=1 for exactly this cycle. On error, bus_error=1, bridge_read_data=0 and no device was written. dev_req is 0. The next state is always IDLE.
- Latency: with request at cycle 0 and ack at cycle 1, accepted is at cycle 2. A back-to-back request may be presented at cycle 3.
- Request inputs are ignored outside IDLE; a request changed mid-transaction has no effect.
- An ack arriving in the same cycle as the timeout takes priority, so there is no error.
- interrupt_request = {3'b000, ext_irq, t1_irq, t0_irq}, registered with one cycle of delay. It is independent of the transaction state machine.
- bridge_read_data holds its value until the next RESP.

Test Plan:
- Word load from 0x0000_0010, DM acks in cycle 1 with dm_rdata=0xDEADBEEF → accepted at cycle 2, read_data=0xDEADBEEF, bus_error=0, dev_be=1111.
- Byte store 0xAB to 0x0000_0013 → dev_be=1000, dev_wdata=0xABABABAB, dev_we=1, one accepted pulse.
- Half load from 0x0000_0002 with dm_rdata=0x1234_5678 → read_data=0x0000_1234. Half load from 0x0000_0003 → immediate error: accepted with bus_error=1, no dev_req.
- Word load from 0x0000_7F10 where Timer1 never acks, TIMEOUT=16 → dev_req stays high 16 cycles, then accepted with bus_error=1 and read_data=0. Store to 0x0000_7F08 → error, no dev_req.
- Reset deasserted-to-asserted (reset=0) in WAIT → dev_req, dev_sel and accepted drop immediately. After release, a new load completes normally.
- t1_irq pulse at cycle 5 → interrupt_request=6'b000010 at cycle 6 only. ext_irq held → bit [4] set throughout a concurrent transaction.
